// File: rtl/servant_uart_wb_master.sv
// servant_uart_wb_master: UART (8N1) command frames -> single Wishbone cycles.
// Host sends 'W' + adr[4] + dat[4] or 'R' + adr[4]; replies 'K' or rdt[4].
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_rx / o_tx      UART receive (async, idle high) / transmit (idle high)
//   o_wb_*           Wishbone initiator: adr, dat, sel (always 4'hf), we, cyc
//   i_wb_rdt/ack     Wishbone read data and acknowledge
//   o_busy           high whenever the command FSM is not idle
module servant_uart_wb_master #(
    parameter int CLKS_PER_BIT = 139,
    parameter int TIMEOUT      = 65535
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx,
    output logic        o_tx,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_BUS  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] TMO_END  = 32'(TIMEOUT);

    // RX synchronizer and deserializer
    logic        rx_meta_q, rx_meta_d;
    logic        rx_sync_q, rx_sync_d;
    logic        rx_prev_q, rx_prev_d;
    logic [1:0]  rx_st_q, rx_st_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_done;
    logic        rx_ferr;

    // Command FSM, bus side and TX serializer
    logic [2:0]  st_q, st_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] resp_q, resp_d;
    logic [1:0]  tx_left_q, tx_left_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic        tx_q, tx_d;
    logic [7:0]  cur_byte;
    logic        timeout;

    always_comb begin
        rx_meta_d = i_rx;
        rx_sync_d = rx_meta_q;
        rx_prev_d = rx_sync_q;
        rx_st_d   = rx_st_q;
        rx_cnt_d  = rx_cnt_q + 16'd1;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_done   = 1'b0;
        rx_ferr   = 1'b0;
        case (rx_st_q)
            R_IDLE: begin
                rx_cnt_d = 16'd0;
                if (rx_prev_q && !rx_sync_q) rx_st_d = R_START;
            end
            R_START: begin
                // A line that is high again mid start bit was a glitch
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d = 16'd0;
                    rx_bit_d = 3'd0;
                    rx_st_d  = rx_sync_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d = 16'd0;
                    rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
                end
            end
            default: begin
                // Leave at mid stop bit so the next start edge is seen
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d = 16'd0;
                    rx_st_d  = R_IDLE;
                    rx_done  = rx_sync_q;
                    rx_ferr  = !rx_sync_q;
                end
            end
        endcase
    end

    assign cur_byte = resp_q[31:24];
    assign timeout  = (tmo_q == TMO_END) && (rx_st_q == R_IDLE);

    always_comb begin
        st_d      = st_q;
        byte_d    = byte_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        tmo_d     = (tmo_q == TMO_END) ? tmo_q : tmo_q + 32'd1;
        resp_d    = resp_q;
        tx_left_d = tx_left_q;
        tx_cnt_d  = tx_cnt_q;
        tx_bit_d  = tx_bit_q;
        tx_d      = tx_q;
        case (st_q)
            S_IDLE: begin
                tmo_d  = 32'd0;
                byte_d = 2'd0;
                if (rx_done && (rx_sh_q == 8'h57 || rx_sh_q == 8'h52)) begin
                    st_d = S_ADDR;
                    we_d = (rx_sh_q == 8'h57);
                end
            end
            S_ADDR, S_DATA: begin
                if (rx_done) begin
                    tmo_d  = 32'd0;
                    byte_d = byte_q + 2'd1;
                    if (st_q == S_ADDR) adr_d = {adr_q[23:0], rx_sh_q};
                    else                dat_d = {dat_q[23:0], rx_sh_q};
                    if (byte_q == 2'd3) begin
                        if (st_q == S_ADDR && we_q) begin
                            st_d = S_DATA;
                        end else begin
                            st_d  = S_BUS;
                            cyc_d = 1'b1;
                        end
                    end
                end else if (rx_ferr || timeout) begin
                    st_d = S_IDLE;
                end
            end
            S_BUS: begin
                if (i_wb_ack) begin
                    cyc_d     = 1'b0;
                    st_d      = S_RESP;
                    tx_d      = 1'b0;
                    tx_cnt_d  = 16'd0;
                    tx_bit_d  = 4'd0;
                    resp_d    = we_q ? {8'h4B, 24'h0} : i_wb_rdt;
                    tx_left_d = we_q ? 2'd0 : 2'd3;
                end
            end
            default: begin
                // Bit 0 is start, 1..8 data LSB first, 9 stop
                tx_cnt_d = tx_cnt_q + 16'd1;
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = 16'd0;
                    if (tx_bit_q == 4'd9) begin
                        if (tx_left_q == 2'd0) begin
                            st_d = S_IDLE;
                        end else begin
                            tx_left_d = tx_left_q - 2'd1;
                            resp_d    = {resp_q[23:0], 8'h00};
                            tx_bit_d  = 4'd0;
                            tx_d      = 1'b0;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                        tx_d     = (tx_bit_q == 4'd8) ? 1'b1
                                                      : cur_byte[tx_bit_q[2:0]];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= R_IDLE;
            rx_cnt_q  <= 16'd0;
            rx_bit_q  <= 3'd0;
            rx_sh_q   <= 8'd0;
            st_q      <= S_IDLE;
            byte_q    <= 2'd0;
            adr_q     <= 32'd0;
            dat_q     <= 32'd0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            tmo_q     <= 32'd0;
            resp_q    <= 32'd0;
            tx_left_q <= 2'd0;
            tx_cnt_q  <= 16'd0;
            tx_bit_q  <= 4'd0;
            tx_q      <= 1'b1;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            rx_prev_q <= rx_prev_d;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            st_q      <= st_d;
            byte_q    <= byte_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            tmo_q     <= tmo_d;
            resp_q    <= resp_d;
            tx_left_q <= tx_left_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_q      <= tx_d;
        end
    end

    assign o_tx     = tx_q;
    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;
    assign o_wb_sel = 4'hf;
    assign o_wb_we  = we_q;
    assign o_wb_cyc = cyc_q;
    assign o_busy   = (st_q != S_IDLE);

endmodule

// File: tb/tb_servant_uart_wb_master.sv
// tb_servant_uart_wb_master: randomized frames against a frame-level model.
// Monitors log Wishbone cycles and decode UART TX bytes.
module tb_servant_uart_wb_master;

    localparam int CPB = 16;
    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        tx;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt = 32'h0;
    logic        ack = 1'b0;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc_n = 0;

    always #5 clk = ~clk;

    servant_uart_wb_master #(.CLKS_PER_BIT(CPB), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx(rx), .o_tx(tx),
        .o_wb_adr(adr), .o_wb_dat(dat), .o_wb_sel(sel), .o_wb_we(we),
        .o_wb_cyc(cyc), .i_wb_rdt(rdt), .i_wb_ack(ack), .o_busy(busy)
    );

    // Registered-ack slave
    always @(posedge clk) ack <= rst ? 1'b0 : (cyc & ~ack);
    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        int          len;
        int          fall;
    } txn_t;

    txn_t       txq[$];
    txn_t       cur;
    logic [7:0] rxq[$];
    int         startq[$];
    logic [7:0] fr[$];
    logic       cyc_prev = 1'b0;
    logic       busy_prev = 1'b0;
    int         busy_fall = 0;

    always @(negedge clk) begin
        if (cyc) begin
            if (!cyc_prev) begin
                cur.adr = adr; cur.dat = dat;
                cur.we = we; cur.sel = sel; cur.len = 0;
            end
            cur.len++;
        end else if (cyc_prev) begin
            cur.fall = cyc_n;
            txq.push_back(cur);
        end
        cyc_prev = cyc;
        if (busy_prev && !busy) busy_fall = cyc_n;
        busy_prev = busy;
    end

    initial begin : tx_decoder
        logic       tp;
        logic [7:0] b;
        tp = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && tp && !tx) begin
                startq.push_back(cyc_n);
                repeat (CPB + CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    b[i] = tx;
                    repeat (CPB) @(negedge clk);
                end
                if (tx) rxq.push_back(b);
            end
            tp = tx;
        end
    end

    task automatic clear_logs();
        txq.delete(); rxq.delete(); startq.delete();
    endtask

    task automatic put_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) fr.push_back(w[i*8 +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopv);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stopv;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        if (!stopv) repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic send_frame(input int bad);
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i], i != bad);
            if (i == bad) break;
        end
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        repeat (4) @(negedge clk);
    endtask

    // Frame-level model: what a complete frame should do on the bus and UART
    function automatic void model(input logic [31:0] rd, output bit v,
                                  output bit mwe, output logic [31:0] madr,
                                  output logic [31:0] mdat, output int nr,
                                  output logic [31:0] mresp);
        v = 0; mwe = 0; madr = 0; mdat = 0; nr = 0; mresp = 0;
        if (fr.size() >= 5 && (fr[0] == 8'h52 ||
            (fr[0] == 8'h57 && fr.size() >= 9))) begin
            v = 1;
            mwe = (fr[0] == 8'h57);
            madr = {fr[1], fr[2], fr[3], fr[4]};
            if (mwe) begin
                mdat = {fr[5], fr[6], fr[7], fr[8]};
                nr = 1; mresp = {8'h4B, 24'h0};
            end else begin
                nr = 4; mresp = rd;
            end
        end
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx got=%b exp=1", tx); end
        checks++; if (cyc !== 1'b0) begin errors++; $display("FAIL rst_cyc got=%b exp=0", cyc); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", we); end
        checks++; if (adr !== 32'h0) begin errors++; $display("FAIL rst_adr got=%h exp=0", adr); end
        checks++; if (dat !== 32'h0) begin errors++; $display("FAIL rst_dat got=%h exp=0", dat); end
        checks++; if (sel !== 4'hf) begin errors++; $display("FAIL rst_sel got=%h exp=f", sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    endtask

    task automatic test_write();
        bit ok, v, mwe;
        logic [31:0] madr, mdat, mresp, a, d;
        int nr;
        for (int it = 0; it < 3; it++) begin
            a = (it == 0) ? 32'h40000008 : $urandom;
            d = (it == 0) ? 32'hDEADBEEF : $urandom;
            rdt = $urandom;
            fr.delete(); fr.push_back(8'h57); put_word(a); put_word(d);
            model(rdt, v, mwe, madr, mdat, nr, mresp);
            clear_logs();
            send_frame(-1);
            wait_idle(50 * CPB, ok);
            checks++; if (!ok) begin errors++; $display("FAIL wr_idle busy=%b exp=0", busy); end
            checks++; if (txq.size() != 1) begin errors++; $display("FAIL wr_ncyc got=%0d exp=1", txq.size()); end
            if (txq.size() >= 1) begin
                checks++; if (txq[0].adr !== madr) begin errors++; $display("FAIL wr_adr got=%h exp=%h", txq[0].adr, madr); end
                checks++; if (txq[0].dat !== mdat) begin errors++; $display("FAIL wr_dat got=%h exp=%h", txq[0].dat, mdat); end
                checks++; if (txq[0].we !== mwe) begin errors++; $display("FAIL wr_we got=%b exp=%b", txq[0].we, mwe); end
                checks++; if (txq[0].sel !== 4'hf) begin errors++; $display("FAIL wr_sel got=%h exp=f", txq[0].sel); end
                checks++; if (txq[0].len != 2) begin errors++; $display("FAIL wr_cyclen got=%0d exp=2", txq[0].len); end
            end
            checks++; if (rxq.size() != nr) begin errors++; $display("FAIL wr_nresp got=%0d exp=%0d", rxq.size(), nr); end
            for (int j = 0; j < nr && j < rxq.size(); j++) begin
                checks++;
                if (rxq[j] !== mresp[31-8*j -: 8]) begin
                    errors++; $display("FAIL wr_resp%0d got=%h exp=%h", j, rxq[j], mresp[31-8*j -: 8]);
                end
            end
        end
    endtask

    task automatic test_read();
        bit ok, v, mwe;
        logic [31:0] madr, mdat, mresp, a;
        int nr;
        for (int it = 0; it < 3; it++) begin
            a = (it == 0) ? 32'h80000000 : $urandom;
            rdt = (it == 0) ? 32'h12345678 : $urandom;
            fr.delete(); fr.push_back(8'h52); put_word(a);
            model(rdt, v, mwe, madr, mdat, nr, mresp);
            clear_logs();
            send_frame(-1);
            wait_idle(60 * CPB, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rd_idle busy=%b exp=0", busy); end
            checks++; if (txq.size() != 1) begin errors++; $display("FAIL rd_ncyc got=%0d exp=1", txq.size()); end
            if (txq.size() >= 1) begin
                checks++; if (txq[0].adr !== madr) begin errors++; $display("FAIL rd_adr got=%h exp=%h", txq[0].adr, madr); end
                checks++; if (txq[0].we !== mwe) begin errors++; $display("FAIL rd_we got=%b exp=%b", txq[0].we, mwe); end
                checks++; if (txq[0].len != 2) begin errors++; $display("FAIL rd_cyclen got=%0d exp=2", txq[0].len); end
                if (startq.size() >= 1) begin
                    checks++; if (startq[0] != txq[0].fall) begin errors++; $display("FAIL rd_txstart got=%0d exp=%0d", startq[0], txq[0].fall); end
                end
            end
            checks++; if (rxq.size() != nr) begin errors++; $display("FAIL rd_nresp got=%0d exp=%0d", rxq.size(), nr); end
            for (int j = 0; j < nr && j < rxq.size(); j++) begin
                checks++;
                if (rxq[j] !== mresp[31-8*j -: 8]) begin
                    errors++; $display("FAIL rd_resp%0d got=%h exp=%h", j, rxq[j], mresp[31-8*j -: 8]);
                end
            end
            checks++;
            if (startq.size() == 0 || busy_fall - startq[0] != 10 * CPB * nr) begin
                errors++; $display("FAIL rd_txlen got=%0d exp=%0d", startq.size() ? busy_fall - startq[0] : -1, 10 * CPB * nr);
            end
        end
    endtask

    task automatic test_bad_cmd();
        bit ok, v, mwe;
        logic [31:0] madr, mdat, mresp;
        int nr;
        fr.delete(); fr.push_back(8'h41);
        clear_logs();
        send_frame(-1);
        repeat (4 * CPB) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_busy got=%b exp=0", busy); end
        checks++; if (txq.size() + rxq.size() != 0) begin errors++; $display("FAIL bad_activity got=%0d exp=0", txq.size() + rxq.size()); end
        rdt = $urandom;
        fr.delete(); fr.push_back(8'h52); put_word($urandom);
        model(rdt, v, mwe, madr, mdat, nr, mresp);
        send_frame(-1);
        wait_idle(60 * CPB, ok);
        checks++; if (txq.size() != 1 || txq[0].adr !== madr) begin errors++; $display("FAIL bad_then_rd ncyc=%0d exp adr=%h", txq.size(), madr); end
        checks++; if (rxq.size() != 4 || {rxq[0], rxq[1], rxq[2], rxq[3]} !== mresp) begin errors++; $display("FAIL bad_then_rd_resp n=%0d exp=%h", rxq.size(), mresp); end
    endtask

    task automatic test_framing();
        bit ok, v, mwe;
        logic [31:0] madr, mdat, mresp;
        int nr;
        fr.delete(); fr.push_back(8'h52); put_word(32'h80000000);
        clear_logs();
        send_frame(2);
        repeat (3 * CPB) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy got=%b exp=0", busy); end
        checks++; if (txq.size() != 0) begin errors++; $display("FAIL ferr_ncyc got=%0d exp=0", txq.size()); end
        fr.delete(); fr.push_back(8'h57); put_word($urandom); put_word($urandom);
        model(rdt, v, mwe, madr, mdat, nr, mresp);
        send_frame(-1);
        wait_idle(50 * CPB, ok);
        checks++; if (txq.size() != 1 || txq[0].adr !== madr || txq[0].dat !== mdat) begin errors++; $display("FAIL ferr_then_wr ncyc=%0d exp adr=%h dat=%h", txq.size(), madr, mdat); end
        checks++; if (rxq.size() != 1 || rxq[0] !== 8'h4B) begin errors++; $display("FAIL ferr_then_wr_resp n=%0d exp=4b", rxq.size()); end
    endtask

    task automatic test_glitch();
        bit seen;
        clear_logs();
        seen = 1'b0;
        @(posedge clk);
        rx = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        rx = 1'b1;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL glitch_busy got=1 exp=0"); end
        checks++; if (txq.size() != 0) begin errors++; $display("FAIL glitch_ncyc got=%0d exp=0", txq.size()); end
    endtask

    task automatic test_timeout();
        fr.delete(); fr.push_back(8'h57); fr.push_back(8'h00);
        clear_logs();
        send_frame(-1);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_midframe_busy got=%b exp=1", busy); end
        repeat (TMO + 10) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got=%b exp=0", busy); end
        checks++; if (txq.size() + rxq.size() != 0) begin errors++; $display("FAIL tmo_activity got=%0d exp=0", txq.size() + rxq.size()); end
    endtask

    task automatic test_reset_mid();
        bit low;
        rdt = $urandom;
        fr.delete(); fr.push_back(8'h52); put_word($urandom);
        clear_logs();
        send_frame(-1);
        low = 1'b0;
        for (int i = 0; i < 4 * CPB; i++) begin
            @(negedge clk);
            if (!tx) begin low = 1'b1; break; end
        end
        checks++; if (!low) begin errors++; $display("FAIL rstmid_start got=1 exp=0"); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
        checks++; if (cyc !== 1'b0) begin errors++; $display("FAIL rstmid_cyc got=%b exp=0", cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        clear_logs();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_cmd();
        test_framing();
        test_glitch();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/servant_uart_wb_master.md
# servant_uart_wb_master

Debug/loader bus initiator for the servant SoC. It receives 8N1 UART command frames from a host and turns each one into a single 32-bit Wishbone read or write cycle. It drives the same CPU-side Wishbone port that the address-decoding mux responds on, so it can poke GPIO, timer or memory without the core. It answers every frame over UART TX with the read data or a write acknowledge.

## Interface
Parameters:
- CLKS_PER_BIT, 139, clocks per UART bit (16 MHz / 115200); minimum 8.
- TIMEOUT, 65535, maximum idle clocks between bytes of one frame before the frame is aborted.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset: synchronous, active-high.
- i_rx  in  1  UART receive line, asynchronous, idle high.
- o_tx  out  1  UART transmit line, idle high.
- o_wb_adr  out  32  Wishbone address.
- o_wb_dat  out  32  Wishbone write data.
- o_wb_sel  out  4  byte selects; constant 4'hf.
- o_wb_we  out  1  write enable.
- o_wb_cyc  out  1  cycle/strobe.
- i_wb_rdt  in  32  read data.
- i_wb_ack  in  1  cycle acknowledge.
- o_busy  out  1  high in every state except IDLE.

## Operation
- Frame format: byte 0 is the command: 0x57 ('W') for write, 0x52 ('R') for read. Next come 4 address bytes, MSB first. A write then carries 4 data bytes, MSB first.
- Response: a read returns 4 data bytes, MSB first. A write returns the single byte 0x4B ('K').
- Any other command byte is discarded and the block stays in IDLE with no response.
- RX path:
  - i_rx passes through a 2-FF synchronizer.
  - A falling edge starts a byte. The start bit is re-checked at CLKS_PER_BIT/2; if high, the edge is treated as a glitch and ignored.
  - Data bits are sampled mid-bit, LSB first, then the stop bit is sampled.
  - A stop bit of 0 is a framing error: the byte is dropped and the FSM returns to IDLE.
- FSM states:
  - IDLE: valid command byte -> ADDR, byte counter 0.
  - ADDR: 4 bytes shifted into o_wb_adr, then -> DATA for a write or BUS for a read.
  - DATA: 4 bytes shifted into o_wb_dat, then -> BUS.
  - BUS: o_wb_cyc=1 until i_wb_ack is sampled high, then -> RESP.
  - RESP: transmit the response bytes back-to-back, then -> IDLE.
- Inter-byte timeout: in ADDR and DATA, a counter is cleared on every received byte. When it reaches TIMEOUT with no new start bit in progress, the FSM returns to IDLE.
- Bytes received in BUS or RESP are discarded. The RX deserializer keeps running so it stays bit-aligned.
- Read data is latched from i_wb_rdt on the edge where ack is sampled. o_wb_adr and o_wb_dat hold their values after the cycle ends.

## Timing
- Reset values: o_tx=1, o_wb_cyc=0, o_wb_we=0, o_wb_adr=0, o_wb_dat=0, o_wb_sel=4'hf, o_busy=0, FSM=IDLE, all counters 0.
- o_wb_cyc rises one clock after the stop-bit sample of the last frame byte. o_wb_we is valid in that same cycle.
- o_wb_cyc falls on the clock edge where i_wb_ack=1 is sampled. Against the registered-ack mux this gives exactly 2 cycles with cyc high.
- The TX start bit begins the clock after ack is sampled.
- Each TX byte is exactly 10*CLKS_PER_BIT clocks: start 0, 8 data bits LSB first, stop 1. There are no idle cycles between response bytes.
- o_busy falls the cycle after the final stop bit completes.
- Reset mid-operation takes effect at the next edge: o_wb_cyc drops, o_tx goes high (a partial TX byte is truncated), and the partial frame is discarded.
- i_wb_ack outside BUS is ignored.

## Test plan
- Write frame 57 40 00 00 08 DE AD BE EF -> one cycle with adr=0x40000008, dat=0xDEADBEEF, we=1, sel=f, cyc high 2 cycles; TX returns 0x4B.
- Read frame 52 80 00 00 00 with rdt=0x12345678 at ack -> we=0, adr=0x80000000; TX returns 12 34 56 78 with no inter-byte gap (40*CLKS_PER_BIT clocks total).
- Command 0x41 then a valid read frame -> 0x41 produces no cycle and no response; the read completes normally.
- Framing error (stop bit 0) on address byte 2 -> no cycle, FSM in IDLE; a following valid frame completes.
- A pulse on i_rx shorter than CLKS_PER_BIT/2 in IDLE -> ignored, o_busy stays 0.
- Timeout and reset:
  - Send 57 00; wait TIMEOUT+10 clocks -> o_busy=0, no cycle.
  - Assert i_rst mid-response -> o_tx=1, o_wb_cyc=0 the next cycle.
